// File: rtl/reg_set_8.sv
// reg_set_8: two independent parallel-load register lanes.
// Both lanes load on every rising clk edge; rst is synchronous, active-high
// and takes priority over the load.
// Optional build macro REG_SET_8_INIT_EN: when defined, both registers carry
// a power-up value equal to their reset value, so q1/q2 are defined before
// the first clock edge. When undefined, q1/q2 are unknown until that edge.
module reg_set_8 #(
  parameter int unsigned          WIDTH    = 8,
  parameter logic [WIDTH-1:0]     RST_VAL1 = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0]     RST_VAL2 = {WIDTH{1'b0}}
) (
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2
);

`ifdef REG_SET_8_INIT_EN
  // Power-up value matches the reset value so outputs are never unknown.
  logic [WIDTH-1:0] q1_r = RST_VAL1;
  logic [WIDTH-1:0] q2_r = RST_VAL2;
`else
  logic [WIDTH-1:0] q1_r;
  logic [WIDTH-1:0] q2_r;
`endif

  // Lane 1: synchronous reset has priority, otherwise capture d1.
  always_ff @(posedge clk) begin
    if (rst) begin
      q1_r <= RST_VAL1;
    end else begin
      q1_r <= d1;
    end
  end

  // Lane 2: independent of lane 1, same reset/load rule.
  always_ff @(posedge clk) begin
    if (rst) begin
      q2_r <= RST_VAL2;
    end else begin
      q2_r <= d2;
    end
  end

  assign q1 = q1_r;
  assign q2 = q2_r;

endmodule

// File: tb/tb_reg_set_8.sv
// tb_reg_set_8: scoreboard bench for reg_set_8.
// A reference model turns the inputs present at each rising edge into the
// expected outputs and queues them; a monitor pops and compares shortly after
// each edge and also checks that q holds steady mid-cycle.
module tb_reg_set_8;

  localparam int unsigned WIDTH = 8;
  localparam logic [WIDTH-1:0] RV1 = 8'h00;
  localparam logic [WIDTH-1:0] RV2 = 8'h00;
  localparam int unsigned N_RAND = 300;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] q1;
  logic [WIDTH-1:0] q2;

  int errors = 0;
  int checks = 0;
  bit stim_done = 1'b0;
  bit have_exp = 1'b0;

  logic [2*WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0]   cur_q1;
  logic [WIDTH-1:0]   cur_q2;

  reg_set_8 #(
    .WIDTH   (WIDTH),
    .RST_VAL1(RV1),
    .RST_VAL2(RV2)
  ) dut (
    .q1 (q1),
    .q2 (q2),
    .clk(clk),
    .rst(rst),
    .d1 (d1),
    .d2 (d2)
  );

  // 20 ns period, first rising edge at 20 ns.
  initial begin
    clk = 1'b0;
    #20;
    forever begin
      clk = 1'b1;
      #10;
      clk = 1'b0;
      #10;
    end
  end

  // Reference model: a register pair captures the edge-time inputs.
  always @(posedge clk) begin
    if (rst) exp_q.push_back({RV1, RV2});
    else     exp_q.push_back({d1, d2});
  end

  // Monitor: compare 1 ns after each edge.
  always @(posedge clk) begin
    logic [2*WIDTH-1:0] e;
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty t=%0t", $time);
    end else begin
      e = exp_q.pop_front();
      cur_q1 = e[2*WIDTH-1:WIDTH];
      cur_q2 = e[WIDTH-1:0];
      have_exp = 1'b1;
      if (q1 !== cur_q1 || q2 !== cur_q2) begin
        errors++;
        $display("FAIL edge_load t=%0t q1=%h q2=%h expected q1=%h q2=%h",
                 $time, q1, q2, cur_q1, cur_q2);
      end
    end
  end

  // Mid-cycle hold: q must not follow d or rst between edges.
  always @(negedge clk) begin
    #6;
    if (have_exp) begin
      checks++;
      if (q1 !== cur_q1 || q2 !== cur_q2) begin
        errors++;
        $display("FAIL mid_cycle_hold t=%0t q1=%h q2=%h expected q1=%h q2=%h",
                 $time, q1, q2, cur_q1, cur_q2);
      end
    end
  end

  // Stimulus: directed test-plan sequence, then randomized traffic.
  initial begin
    rst = 1'b0;
    d1  = 8'h00;
    d2  = 8'h00;
`ifdef REG_SET_8_INIT_EN
    #1;
    checks++;
    if (q1 !== RV1 || q2 !== RV2) begin
      errors++;
      $display("FAIL powerup_value q1=%h q2=%h expected q1=%h q2=%h", q1, q2, RV1, RV2);
    end
    #14;
`else
    #15;
`endif
    d1 = 8'hBC;                 // t=15, captured at 20
    #20; d1 = 8'h00;            // t=35, captured at 40
    #30; d1 = 8'h53;            // t=65, captured at 80 (not at 60)
    #25; rst = 1'b1;            // t=90, reset from the 100 edge
    #35; d1 = 8'hFF; d2 = 8'hA5; // t=125, ignored while rst=1
    #25; rst = 1'b0;            // t=150, edge 160 loads FF/A5
    #15;                        // t=165
    for (int i = 0; i < int'(N_RAND); i++) begin
      @(posedge clk);
      #5;
      d1  = WIDTH'($urandom);
      d2  = WIDTH'($urandom);
      rst = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) begin
        #8;
        d1 = WIDTH'($urandom);
        if ($urandom_range(0, 1) == 0) rst = ~rst;
      end
    end
    @(posedge clk);
    @(posedge clk);
    #3;
    stim_done = 1'b1;
  end

  // Finish after stimulus completes, with a hard time bound as a backstop.
  initial begin
    fork
      wait (stim_done);
      #100000;
    join_any
    disable fork;
    if (!stim_done) begin
      errors++;
      $display("FAIL timeout t=%0t", $time);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
